// File: rtl/debug_pkg.sv
// Shared types, constants and RV32I encode helpers for the debug instruction encoder.
package debug_pkg;

  typedef enum logic [1:0] {
    OP_READ_REG  = 2'b00,
    OP_WRITE_REG = 2'b01,
    OP_READ_MEM  = 2'b10,
    OP_FLUSH     = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } enc_state_t;

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [31:0] RV_NOP     = 32'h00000013;

  localparam logic [11:0] MAILBOX_OFF_DEF = 12'h400;
  localparam logic [4:0]  SCRATCH_REG_DEF = 5'd31;
  localparam int          HAZ_NOPS_DEF    = 2;
  localparam int          NOP_DRAIN_DEF   = 3;

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm20);
    return {imm20, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm12);
    return {imm12, rs1, 3'b000, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm12);
    return {imm12, rs1, 3'b010, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm12);
    return {imm12[11:5], rs2, rs1, 3'b010, imm12[4:0], OPC_STORE};
  endfunction

  // Index of the final real instruction for each command; drain-only commands never use it.
  function automatic logic [1:0] last_step(input cmd_op_t op);
    case (op)
      OP_WRITE_REG: return 2'd1;
      OP_READ_MEM:  return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_split.sv
// Splits a 32-bit constant into LUI/ADDI halves. ADDI sign-extends its 12-bit
// immediate, so the upper part absorbs bit 11 to cancel the extension.
module rv_imm_split
  import debug_pkg::*;
(
  input  logic [31:0] value,
  output logic [19:0] hi,
  output logic [11:0] lo
);

  // Upper part wraps modulo 2^20, which is exactly what LUI+ADDI reconstructs.
  always_comb begin
    lo = value[11:0];
    hi = value[31:12] + {19'd0, value[11]};
  end

endmodule

// File: rtl/debug_instr_encoder.sv
// Turns debugger commands into RV32I instruction words injected into the core.
//
// Handshake rules (both ports): a transfer happens on the cycle where valid and
// ready are both high at the rising clock edge. A producer holding valid keeps
// its payload stable until the transfer; instr is a function of registered state
// only, so it never depends on instr_ready combinationally.
module debug_instr_encoder
  import debug_pkg::*;
#(
  parameter logic [11:0] MAILBOX_OFF = MAILBOX_OFF_DEF,
  parameter logic [4:0]  SCRATCH_REG = SCRATCH_REG_DEF,
  parameter int          HAZ_NOPS    = HAZ_NOPS_DEF,
  parameter int          NOP_DRAIN   = NOP_DRAIN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        busy,
  output logic        done
);

  enc_state_t  state, state_n;
  logic [1:0]  step, step_n;
  logic [7:0]  cnt, cnt_n;

  cmd_op_t     op_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic [19:0] data_hi, addr_hi;
  logic [11:0] data_lo, addr_lo;
  logic [31:0] issue_word;
  logic        accept_cmd;
  logic        fire;
  cmd_op_t     cmd_op_e;

  assign cmd_op_e   = cmd_op_t'(cmd_op);
  assign accept_cmd = cmd_valid && cmd_ready;
  assign fire       = instr_valid && instr_ready;

  rv_imm_split u_split_data (
    .value (data_q),
    .hi    (data_hi),
    .lo    (data_lo)
  );

  rv_imm_split u_split_addr (
    .value (addr_q),
    .hi    (addr_hi),
    .lo    (addr_lo)
  );

  // Command fields are captured only on acceptance, so later cmd_* activity cannot disturb a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_READ_REG;
      rd_q   <= 5'd0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else if (accept_cmd) begin
      op_q   <= cmd_op_e;
      rd_q   <= cmd_reg;
      addr_q <= cmd_addr;
      data_q <= cmd_data;
    end
  end

  // State, step index and NOP counter; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      step  <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      step  <= step_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: steps advance only on an accepted word.
  always_comb begin
    state_n = state;
    step_n  = step;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept_cmd) begin
          step_n = 2'd0;
          cnt_n  = 8'd0;
          if (cmd_op_e == OP_FLUSH || (cmd_op_e == OP_WRITE_REG && cmd_reg == 5'd0))
            state_n = (NOP_DRAIN > 0) ? ST_DRAIN : ST_DONE;
          else
            state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          cnt_n = 8'd0;
          if (step == last_step(op_q))
            state_n = (NOP_DRAIN > 0) ? ST_DRAIN : ST_DONE;
          else if (HAZ_NOPS > 0)
            state_n = ST_GAP;
          else
            step_n = step + 2'd1;
        end
      end
      ST_GAP: begin
        if (fire) begin
          if (cnt == 8'(HAZ_NOPS - 1)) begin
            state_n = ST_ISSUE;
            step_n  = step + 2'd1;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (fire) begin
          if (cnt == 8'(NOP_DRAIN - 1)) begin
            state_n = ST_DONE;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        step_n  = 2'd0;
        cnt_n   = 8'd0;
      end
      default: begin
        state_n = ST_IDLE;
        step_n  = 2'd0;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Real instruction for the current step of the latched command.
  always_comb begin
    issue_word = RV_NOP;
    case (op_q)
      OP_READ_REG:  issue_word = enc_sw(rd_q, 5'd0, MAILBOX_OFF);
      OP_WRITE_REG: issue_word = (step == 2'd0) ? enc_lui(rd_q, data_hi)
                                                : enc_addi(rd_q, rd_q, data_lo);
      OP_READ_MEM: begin
        case (step)
          2'd0:    issue_word = enc_lui(SCRATCH_REG, addr_hi);
          2'd1:    issue_word = enc_lw(SCRATCH_REG, SCRATCH_REG, addr_lo);
          default: issue_word = enc_sw(SCRATCH_REG, 5'd0, MAILBOX_OFF);
        endcase
      end
      default:      issue_word = RV_NOP;
    endcase
  end

  // Outputs decoded from registered state; GAP and DRAIN inject the canonical NOP.
  always_comb begin
    cmd_ready   = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    instr_valid = (state == ST_ISSUE) || (state == ST_GAP) || (state == ST_DRAIN);
    instr       = (state == ST_ISSUE) ? issue_word : RV_NOP;
  end

endmodule

// File: tb/tb_debug_instr_encoder.sv
// Directed bench for debug_instr_encoder: command sequences, backpressure,
// drain-only commands and reset in the middle of a command.
module tb_debug_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_reg;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        busy;
  logic        done;

  localparam logic [31:0] NOP = 32'h00000013;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  debug_instr_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_reg     (cmd_reg),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .busy        (busy),
    .done        (done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the command accepted.
  task automatic send_cmd(input string tag, input logic [1:0] op, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] data);
    int idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) @(negedge clk);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rd;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_reg   = 5'd0;
    cmd_addr  = 32'd0;
    cmd_data  = 32'd0;
  endtask

  // Waits (bounded) for instr_valid, checks the word, lets it be accepted.
  task automatic expect_word(input string tag, input logic [31:0] exp);
    int waited = 0;
    while (instr_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check(tag, instr, exp);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_expected(input string tag);
    int idx = 0;
    logic [31:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      expect_word($sformatf("%s_w%0d", tag, idx), w);
      idx++;
    end
  endtask

  // Called at the negedge right after the last drain NOP was accepted.
  task automatic finish_cmd(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_done_valid"}, 32'(instr_valid), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic push_drain();
    for (int i = 0; i < 3; i++) exp_q.push_back(NOP);
  endtask

  // Directed sequence
  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_reg     = 5'd0;
    cmd_addr    = 32'd0;
    cmd_data    = 32'd0;
    instr_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // READ_REG x5
    send_cmd("rdreg", 2'b00, 5'd5, 32'd0, 32'd0);
    check("rdreg_busy", 32'(busy), 32'd1);
    exp_q.push_back(32'h40502023);
    push_drain();
    run_expected("rdreg");
    finish_cmd("rdreg");

    // WRITE_REG x10, 0x12345678
    send_cmd("wr10", 2'b01, 5'd10, 32'd0, 32'h12345678);
    exp_q.push_back(32'h12345537);
    exp_q.push_back(NOP);
    exp_q.push_back(NOP);
    exp_q.push_back(32'h67850513);
    push_drain();
    run_expected("wr10");
    finish_cmd("wr10");

    // WRITE_REG x1, 0xFFFFF800: upper part wraps to zero
    send_cmd("wr1", 2'b01, 5'd1, 32'd0, 32'hFFFFF800);
    exp_q.push_back(32'h000000B7);
    exp_q.push_back(NOP);
    exp_q.push_back(NOP);
    exp_q.push_back(32'h80008093);
    push_drain();
    run_expected("wr1");
    finish_cmd("wr1");

    // Backpressure on the first LUI plus a stray command offer while busy
    send_cmd("bp", 2'b01, 5'd10, 32'd0, 32'h12345678);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), 32'(instr_valid), 32'd1);
      check($sformatf("bp_hold_instr%0d", i), instr, 32'h12345537);
      if (i == 2) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_reg   = 5'd3;
        cmd_data  = 32'hCAFEF00D;
        check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      end else begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_reg   = 5'd0;
        cmd_data  = 32'd0;
      end
      @(negedge clk);
    end
    cmd_valid   = 1'b0;
    instr_ready = 1'b1;
    exp_q.push_back(32'h12345537);
    exp_q.push_back(NOP);
    exp_q.push_back(NOP);
    exp_q.push_back(32'h67850513);
    push_drain();
    run_expected("bp");
    finish_cmd("bp");

    // WRITE_REG x0: drain only
    send_cmd("wr0", 2'b01, 5'd0, 32'd0, 32'hDEADBEEF);
    push_drain();
    run_expected("wr0");
    finish_cmd("wr0");

    // FLUSH: drain only
    send_cmd("flush", 2'b11, 5'd7, 32'h12345678, 32'h87654321);
    push_drain();
    run_expected("flush");
    finish_cmd("flush");

    // READ_MEM with reset pulsed after the LUI is accepted
    send_cmd("rmab", 2'b10, 5'd0, 32'h80001FFC, 32'd0);
    expect_word("rmab_lui", 32'h80002FB7);
    rst_n = 1'b0;
    #1;
    check("rmab_rst_valid", 32'(instr_valid), 32'd0);
    check("rmab_rst_instr", instr, NOP);
    check("rmab_rst_busy", 32'(busy), 32'd0);
    check("rmab_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmab_post_valid", 32'(instr_valid), 32'd0);

    // Full READ_MEM after reset starts from the LUI again
    send_cmd("rm", 2'b10, 5'd0, 32'h80001FFC, 32'd0);
    exp_q.push_back(32'h80002FB7);
    exp_q.push_back(NOP);
    exp_q.push_back(NOP);
    exp_q.push_back(32'hFFCFAF83);
    exp_q.push_back(NOP);
    exp_q.push_back(NOP);
    exp_q.push_back(32'h41F02023);
    push_drain();
    run_expected("rm");
    finish_cmd("rm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
